bcd_display_ctrl: RTL and testbench

- Sequencing controller that converts a binary count into DIGITS 4-bit display digits for the seven-segment driver (SevenSeg digit inputs).
- Replaces combinational divide/modulo with an iterative double-dabble (shift-add-3) engine, one shift per clock.
- Also offers a hex bypass mode (nibble split).
- Sits between any binary counter/requester and the segment driver, using a valid/ready handshake on input and a registered, held digit bus on output.

---
 rtl/display_pkg.sv | 30 +++
 rtl/bcd_add3_column.sv | 17 +
 rtl/bcd_display_ctrl.sv | 111 +++++++++++
 tb/tb_bcd_display_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the binary-to-display-digit controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned DIGIT_W        = 4;
  localparam logic [3:0]  BCD_ADD_THRESH = 4'd5;
  localparam logic [3:0]  BCD_ADD_VAL    = 4'd3;

  // Smallest value that no longer fits in n decimal digits.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Smallest value that no longer fits in n hex digits.
  function automatic logic [63:0] pow16(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd16;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_column.sv
// Double-dabble correction: every BCD digit >= 5 gets +3 before the next shift.
module bcd_add3_column
  import display_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic [DIGIT_W*DIGITS-1:0] scratch,
  output logic [DIGIT_W*DIGITS-1:0] corrected_c
);

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
    logic [DIGIT_W-1:0] d;
    assign d = scratch[k*DIGIT_W +: DIGIT_W];
    assign corrected_c[k*DIGIT_W +: DIGIT_W] = (d >= BCD_ADD_THRESH) ? d + BCD_ADD_VAL : d;
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Converts a binary value into held display digits, either decimal via an
// iterative shift-add-3 engine (one bit per clock) or hex via a nibble split.
module bcd_display_ctrl
  import display_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 10,
  parameter int unsigned DIGITS    = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_WIDTH-1:0]   in_value,
  input  logic                   hex_mode,
  output logic [4*DIGITS-1:0]    digits,
  output logic                   digits_valid,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned SCR_W     = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W     = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] DEC_LIMIT = pow10(DIGITS);
  localparam logic [63:0] HEX_LIMIT = pow16(DIGITS);

  state_e               state_q, state_d;
  logic                 accept_c, shift_c, load_c, ovf_c;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [SCR_W-1:0]     scratch_q, corr_c, result_c;
  logic [CNT_W-1:0]     cnt_q;
  logic                 hex_q, ovf_q;

  bcd_add3_column #(.DIGITS(DIGITS)) u_add3 (
    .scratch     (scratch_q),
    .corrected_c (corr_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    shift_c  = 1'b0;
    load_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = hex_mode ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        load_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Range limit is decided at capture so the engine never needs to inspect lost bits.
  always_comb begin
    ovf_c = hex_mode ? (64'(in_value) >= HEX_LIMIT) : (64'(in_value) >= DEC_LIMIT);
  end

  always_comb begin
    result_c = hex_q ? SCR_W'(bin_q) : scratch_q;
    if (ovf_q) result_c = hex_q ? {DIGITS{4'hF}} : {DIGITS{4'h9}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q        <= '0;
      scratch_q    <= '0;
      cnt_q        <= '0;
      hex_q        <= 1'b0;
      ovf_q        <= 1'b0;
      digits       <= '0;
      digits_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      digits_valid <= load_c;
      if (accept_c) begin
        bin_q     <= in_value;
        hex_q     <= hex_mode;
        ovf_q     <= ovf_c;
        scratch_q <= '0;
        cnt_q     <= CNT_W'(BIN_WIDTH);
      end
      if (shift_c) begin
        scratch_q <= {corr_c[SCR_W-2:0], bin_q[BIN_WIDTH-1]};
        bin_q     <= {bin_q[BIN_WIDTH-2:0], 1'b0};
        cnt_q     <= cnt_q - CNT_W'(1);
      end
      if (load_c) begin
        digits   <= result_c;
        overflow <= ovf_q;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == IDLE) && reset_n;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl with default parameters (10-bit input, 3 digits).
module tb_bcd_display_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        hex_mode = 1'b0;
  logic [9:0]  in_value = '0;
  logic        in_ready, digits_valid, overflow, busy;
  logic [11:0] digits;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_display_ctrl #(.BIN_WIDTH(10), .DIGITS(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_value     (in_value),
    .hex_mode     (hex_mode),
    .digits       (digits),
    .digits_valid (digits_valid),
    .overflow     (overflow),
    .busy         (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, presents one request, returns the published result and its edge latency.
  task automatic do_conv(input logic [9:0] v, input logic hx,
                         output logic [11:0] d, output logic ov, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    in_value = v;
    hex_mode = hx;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (digits_valid) begin
        lat = i;
        break;
      end
    end
    d  = digits;
    ov = overflow;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if ({digits, digits_valid, overflow, busy} !== 15'd0) begin n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {digits, digits_valid, overflow, busy}); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++;
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    step();
    step();
    reset_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_dec_999();
    int busy_cnt, lat;
    in_value = 10'd999;
    hex_mode = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    busy_cnt = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_cnt++;
      step();
      if (digits_valid) begin
        lat = i;
        break;
      end
    end
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL dec999_latency: got %0d want 11", lat); end
    n_cmp++; if (digits !== 12'h999) begin n_bad++; $display("FAIL dec999_digits: got %h want 999", digits); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL dec999_overflow: got %b want 0", overflow); end
    n_cmp++; if (busy_cnt !== 11) begin n_bad++; $display("FAIL dec999_busy_cycles: got %0d want 11", busy_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dec999_busy_after: got %b want 0", busy); end
    step();
    n_cmp++; if (digits_valid !== 1'b0) begin n_bad++; $display("FAIL dec999_pulse_width: got %b want 0", digits_valid); end
    n_cmp++; if (digits !== 12'h999) begin n_bad++; $display("FAIL dec999_hold: got %h want 999", digits); end
  endtask

  task automatic test_back_to_back();
    int rdy_seen, lat;
    in_value = 10'd0;
    hex_mode = 1'b0;
    in_valid = 1'b1;
    step();
    in_value = 10'd1;
    rdy_seen = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (in_ready) rdy_seen++;
      step();
      if (digits_valid) begin
        lat = i;
        break;
      end
    end
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 11", lat); end
    n_cmp++; if (digits !== 12'h000) begin n_bad++; $display("FAIL b2b_first_digits: got %h want 000", digits); end
    n_cmp++; if (rdy_seen !== 0) begin n_bad++; $display("FAIL b2b_ready_while_busy: got %0d want 0", rdy_seen); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_update: got %b want 1", in_ready); end
    step();
    n_cmp++; if ({busy, in_ready} !== 2'b10) begin n_bad++;
      $display("FAIL b2b_second_accept: got busy/ready %b want 10", {busy, in_ready}); end
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (digits_valid) begin
        lat = i;
        break;
      end
    end
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 11", lat); end
    n_cmp++; if (digits !== 12'h001) begin n_bad++; $display("FAIL b2b_second_digits: got %h want 001", digits); end
  endtask

  task automatic test_overflow();
    logic [11:0] d;
    logic ov;
    int lat;
    do_conv(10'd1000, 1'b0, d, ov, lat);
    n_cmp++; if ({ov, d} !== {1'b1, 12'h999}) begin n_bad++; $display("FAIL ovf_1000: got %b/%h want 1/999", ov, d); end
    do_conv(10'd1023, 1'b0, d, ov, lat);
    n_cmp++; if ({ov, d} !== {1'b1, 12'h999}) begin n_bad++; $display("FAIL ovf_1023: got %b/%h want 1/999", ov, d); end
    do_conv(10'd5, 1'b0, d, ov, lat);
    n_cmp++; if ({ov, d} !== {1'b0, 12'h005}) begin n_bad++; $display("FAIL ovf_clear_5: got %b/%h want 0/005", ov, d); end
  endtask

  task automatic test_hex();
    logic [11:0] d;
    logic ov;
    int lat;
    do_conv(10'h3E7, 1'b1, d, ov, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL hex_latency: got %0d want 1", lat); end
    n_cmp++; if ({ov, d} !== {1'b0, 12'h3E7}) begin n_bad++; $display("FAIL hex_3e7: got %b/%h want 0/3e7", ov, d); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hex_ready_after: got %b want 1", in_ready); end
    do_conv(10'h00A, 1'b1, d, ov, lat);
    n_cmp++; if ({ov, d} !== {1'b0, 12'h00A}) begin n_bad++; $display("FAIL hex_00a: got %b/%h want 0/00a", ov, d); end
    hex_mode = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [11:0] d;
    logic ov;
    int lat, pulses;
    in_value = 10'd512;
    hex_mode = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({digits, digits_valid, overflow, busy, in_ready} !== 16'd0) begin n_bad++;
      $display("FAIL midreset_outputs: got %h want 0", {digits, digits_valid, overflow, busy, in_ready}); end
    step();
    step();
    reset_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (digits_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midreset_no_pulse: got %0d want 0", pulses); end
    do_conv(10'd42, 1'b0, d, ov, lat);
    n_cmp++; if ({ov, d} !== {1'b0, 12'h042}) begin n_bad++; $display("FAIL midreset_42: got %b/%h want 0/042", ov, d); end
  endtask

  task automatic test_input_toggle();
    int lat;
    in_value = 10'd123;
    hex_mode = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      in_value = 10'($urandom);
      hex_mode = 1'($urandom);
      step();
      if (digits_valid) begin
        lat = i;
        break;
      end
    end
    hex_mode = 1'b0;
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL toggle_latency: got %0d want 11", lat); end
    n_cmp++; if ({overflow, digits} !== {1'b0, 12'h123}) begin n_bad++;
      $display("FAIL toggle_123: got %b/%h want 0/123", overflow, digits); end
  endtask

  task automatic test_sweep();
    logic [11:0] d, exp_d;
    logic ov, exp_ov;
    int lat;
    for (int v = 0; v < 1024; v++) begin
      do_conv(10'(v), 1'b0, d, ov, lat);
      exp_ov = (v >= 1000);
      exp_d  = exp_ov ? 12'h999 : {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      n_cmp++; if ({ov, d} !== {exp_ov, exp_d} || lat !== 11) begin n_bad++;
        $display("FAIL sweep_%0d: got %b/%h lat %0d want %b/%h lat 11", v, ov, d, lat, exp_ov, exp_d); end
    end
  endtask

  initial begin
    test_reset();
    test_dec_999();
    test_back_to_back();
    test_overflow();
    test_hex();
    test_reset_mid_shift();
    test_input_toggle();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
